s_axi4l_rd_channel: RTL and testbench

- AXI4-Lite slave read channel; companion to the slave write channel in the same register-slave wrapper.
- Accepts AR requests and issues a single-cycle read request to the register file.
- Waits for the register file's data strobe, then returns the data on R with RRESP.
- One outstanding transaction; no reordering.

---
 rtl/s_axi4l_rd_channel.sv | 113 +++++++++++
 tb/tb_s_axi4l_rd_channel.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/s_axi4l_rd_channel.sv
// rtl/s_axi4l_rd_channel.sv - AXI4-Lite slave read channel bridging AR/R to a register-file read port
// Optional read timeout (SLVERR on a missing data strobe) enabled by AXI4L_RD_TIMEOUT_EN.
module s_axi4l_rd_channel #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      i_axi_clock,
   input  logic                      i_axi_aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0] i_axi_araddr,
   input  logic [2:0]                i_axi_arprot,
   input  logic                      i_axi_araddr_valid,
   output logic                      o_axi_araddr_ready,
   output logic [AXI_DATA_WIDTH-1:0] o_axi_rdata,
   output logic [1:0]                o_axi_rresp,
   output logic                      o_axi_rvalid,
   input  logic                      i_axi_rready,
   output logic [AXI_ADDR_WIDTH-1:0] o_raddr,
   output logic                      o_rreq,
   input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
   input  logic                      i_rdata_valid,
   input  logic                      i_rerr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t                    state;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_DATA_WIDTH-1:0] data_q;
   logic                      err_q;

`ifdef AXI4L_RD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
`endif

   // Protection bits carry no meaning for this register slave.
   logic unused_ok;
   assign unused_ok = &{1'b0, i_axi_arprot, (TIMEOUT_CYCLES > 1)};

   assign o_raddr = addr_q;

   always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
      if (!i_axi_aresetn) begin
         state              <= IDLE;
         o_axi_araddr_ready <= 1'b0;
         o_axi_rvalid       <= 1'b0;
         o_axi_rdata        <= '0;
         o_axi_rresp        <= 2'b00;
         o_rreq             <= 1'b0;
         addr_q             <= '0;
         data_q             <= '0;
         err_q              <= 1'b0;
`ifdef AXI4L_RD_TIMEOUT_EN
         cnt                <= '0;
`endif
      end else begin
         o_rreq <= 1'b0;
         case (state)
            IDLE: begin
               o_axi_araddr_ready <= 1'b1;
               if (i_axi_araddr_valid && o_axi_araddr_ready) begin
                  addr_q             <= i_axi_araddr;
                  o_rreq             <= 1'b1;
                  o_axi_araddr_ready <= 1'b0;
                  state              <= REQ;
`ifdef AXI4L_RD_TIMEOUT_EN
                  cnt                <= '0;
`endif
               end
            end
            REQ, WAIT: begin
               // A strobe arriving on the timeout cycle still wins.
               if (i_rdata_valid) begin
                  data_q <= i_rdata;
                  err_q  <= i_rerr;
                  state  <= RESP;
               end
`ifdef AXI4L_RD_TIMEOUT_EN
               else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
                  state  <= RESP;
               end
`endif
               else begin
                  state <= WAIT;
               end
`ifdef AXI4L_RD_TIMEOUT_EN
               if (cnt != CW'(TIMEOUT_CYCLES))
                  cnt <= cnt + 1'b1;
`endif
            end
            RESP: begin
               // First RESP cycle loads the R channel; handshake only once RVALID is visible.
               if (!o_axi_rvalid) begin
                  o_axi_rvalid <= 1'b1;
                  o_axi_rdata  <= data_q;
                  o_axi_rresp  <= err_q ? 2'b10 : 2'b00;
               end else if (i_axi_rready) begin
                  o_axi_rvalid       <= 1'b0;
                  o_axi_rdata        <= '0;
                  o_axi_rresp        <= 2'b00;
                  o_axi_araddr_ready <= 1'b1;
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_s_axi4l_rd_channel.sv
// tb/tb_s_axi4l_rd_channel.sv - directed self-checking bench for s_axi4l_rd_channel
module tb_s_axi4l_rd_channel;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [3:0]  raddr;
   logic        rreq;
   logic [31:0] rf_data = '0;
   logic        rf_valid = 1'b0;
   logic        rf_err = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   s_axi4l_rd_channel #(
      .AXI_DATA_WIDTH(32),
      .AXI_ADDR_WIDTH(4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_axi_clock       (clk),
      .i_axi_aresetn     (resetn),
      .i_axi_araddr      (araddr),
      .i_axi_arprot      (arprot),
      .i_axi_araddr_valid(arvalid),
      .o_axi_araddr_ready(arready),
      .o_axi_rdata       (rdata),
      .o_axi_rresp       (rresp),
      .o_axi_rvalid      (rvalid),
      .i_axi_rready      (rready),
      .o_raddr           (raddr),
      .o_rreq            (rreq),
      .i_rdata           (rf_data),
      .i_rdata_valid     (rf_valid),
      .i_rerr            (rf_err)
   );

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         if (arready === 1'b1) break;
         @(negedge clk);
      end
      check_value("wait_arready", arready, 1);
   endtask

   // Handshake on the next edge; returns at the negedge of the REQ cycle.
   task automatic do_ar(input logic [3:0] a);
      arvalid = 1'b1;
      araddr  = a;
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check_value("rst_arready", arready, 0);
      check_value("rst_rvalid", rvalid, 0);
      check_value("rst_rdata", rdata, 0);
      check_value("rst_rresp", rresp, 0);
      check_value("rst_rreq", rreq, 0);
      check_value("rst_raddr", raddr, 0);
      resetn = 1'b1;
      @(negedge clk);
      check_value("post_rst_arready", arready, 1);

      // Minimum latency read
      rready = 1'b1;
      do_ar(4'h4);
      check_value("t1_rreq", rreq, 1);
      check_value("t1_raddr", raddr, 4'h4);
      check_value("t1_arready_busy", arready, 0);
      rf_valid = 1'b1;
      rf_data  = 32'hDEADBEEF;
      @(negedge clk);
      rf_valid = 1'b0;
      check_value("t1_rreq_pulse", rreq, 0);
      check_value("t1_rvalid_early", rvalid, 0);
      @(negedge clk);
      check_value("t1_rvalid", rvalid, 1);
      check_value("t1_rdata", rdata, 32'hDEADBEEF);
      check_value("t1_rresp", rresp, 2'b00);
      @(negedge clk);
      check_value("t1_rvalid_drop", rvalid, 0);
      check_value("t1_rdata_clear", rdata, 0);
      check_value("t1_arready_back", arready, 1);

      // Delayed strobe and R backpressure
      wait_idle();
      rready = 1'b0;
      do_ar(4'hC);
      check_value("t2_rreq", rreq, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_value("t2_wait_rreq", rreq, 0);
         check_value("t2_wait_raddr", raddr, 4'hC);
         check_value("t2_wait_arready", arready, 0);
         check_value("t2_wait_rvalid", rvalid, 0);
      end
      rf_valid = 1'b1;
      rf_data  = 32'hA5A50001;
      @(negedge clk);
      rf_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_value("t2_hold_rvalid", rvalid, 1);
         check_value("t2_hold_rdata", rdata, 32'hA5A50001);
         check_value("t2_hold_rresp", rresp, 2'b00);
         check_value("t2_hold_arready", arready, 0);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      check_value("t2_rvalid_drop", rvalid, 0);
      check_value("t2_arready_back", arready, 1);

      // Error response
      wait_idle();
      do_ar(4'h2);
      rf_valid = 1'b1;
      rf_err   = 1'b1;
      rf_data  = 32'h12345678;
      @(negedge clk);
      rf_valid = 1'b0;
      rf_err   = 1'b0;
      @(negedge clk);
      check_value("t3_rvalid", rvalid, 1);
      check_value("t3_rresp", rresp, 2'b10);
      check_value("t3_rdata", rdata, 32'h12345678);
      @(negedge clk);

      // Back-to-back with ARVALID held
      wait_idle();
      arvalid = 1'b1;
      araddr  = 4'h0;
      @(negedge clk);
      check_value("t4a_rreq", rreq, 1);
      check_value("t4a_raddr", raddr, 4'h0);
      araddr   = 4'h8;
      rf_valid = 1'b1;
      rf_data  = 32'h11111111;
      @(negedge clk);
      rf_valid = 1'b0;
      @(negedge clk);
      check_value("t4a_rvalid", rvalid, 1);
      check_value("t4a_rdata", rdata, 32'h11111111);
      @(negedge clk);
      check_value("t4_bubble_arready", arready, 1);
      check_value("t4_bubble_rreq", rreq, 0);
      check_value("t4_bubble_rvalid", rvalid, 0);
      @(negedge clk);
      arvalid = 1'b0;
      check_value("t4b_rreq", rreq, 1);
      check_value("t4b_raddr", raddr, 4'h8);
      rf_valid = 1'b1;
      rf_data  = 32'h22222222;
      @(negedge clk);
      rf_valid = 1'b0;
      @(negedge clk);
      check_value("t4b_rvalid", rvalid, 1);
      check_value("t4b_rdata", rdata, 32'h22222222);
      @(negedge clk);

      // Reset while in WAIT
      wait_idle();
      do_ar(4'h6);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_value("t5_rst_arready", arready, 0);
      check_value("t5_rst_raddr", raddr, 0);
      check_value("t5_rst_rreq", rreq, 0);
      check_value("t5_rst_rvalid", rvalid, 0);
      @(negedge clk);
      resetn   = 1'b1;
      rf_valid = 1'b1;
      rf_data  = 32'h00000BAD;
      @(negedge clk);
      rf_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_value("t5_no_rvalid", rvalid, 0);
         check_value("t5_idle_arready", arready, 1);
         @(negedge clk);
      end

`ifdef AXI4L_RD_TIMEOUT_EN
      // Timeout without strobe
      wait_idle();
      do_ar(4'h3);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check_value("t6_no_early", rvalid, 0);
      end
      @(negedge clk);
      @(negedge clk);
      check_value("t6_rvalid", rvalid, 1);
      check_value("t6_rresp", rresp, 2'b10);
      check_value("t6_rdata", rdata, 0);
      @(negedge clk);

      // Strobe on the final cycle wins
      wait_idle();
      do_ar(4'h5);
      for (int i = 0; i < 15; i++) @(negedge clk);
      check_value("t7_no_early", rvalid, 0);
      rf_valid = 1'b1;
      rf_data  = 32'h5A5A5A5A;
      @(negedge clk);
      rf_valid = 1'b0;
      @(negedge clk);
      check_value("t7_rvalid", rvalid, 1);
      check_value("t7_rresp", rresp, 2'b00);
      check_value("t7_rdata", rdata, 32'h5A5A5A5A);
      @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
